// File: rtl/rx_inbox_bridge_if.sv
// Byte path between the UART receiver and the CPU INBOX write port.
// Handshake: i_rx_wr is a one-cycle strobe with no back-pressure, and i_rx_data
// is valid only while it is high. o_wr is a one-cycle INBOX write strobe, and
// o_data is valid while it is high. i_full is the INBOX full flag; a write is
// only issued when i_full was low one cycle earlier.
interface rx_inbox_bridge_if;
  logic       i_rx_wr;
  logic [7:0] i_rx_data;
  logic       i_full;
  logic       o_wr;
  logic [7:0] o_data;

  // Bridge side.
  modport slave (
    input  i_rx_wr,
    input  i_rx_data,
    input  i_full,
    output o_wr,
    output o_data
  );

  // UART/INBOX side (also used by the testbench).
  modport master (
    output i_rx_wr,
    output i_rx_data,
    output i_full,
    input  o_wr,
    input  o_data
  );
endinterface

// File: rtl/rx_inbox_bridge.sv
// Elastic byte FIFO between the UART RX strobe and the CPU INBOX.
// Bytes drain at most one per three cycles (IDLE -> SEND -> GAP).
// The GAP state lets the INBOX's registered full flag settle before the next decision.
module rx_inbox_bridge #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  rx_inbox_bridge_if.slave         bus,
  input  logic                     i_clr_ovf,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     data_q, data_d;
  logic           push, pop, drop, go_send;

  // Pop is tied to the SEND state. A push at full is accepted when it coincides with the pop.
  always_comb begin
    pop  = (state_q == SEND);
    push = bus.i_rx_wr && ((count_q != CNT_FULL) || pop);
    drop = bus.i_rx_wr && !push;
  end

  // Pointer, occupancy and sticky-overflow next state. A set wins over a clear.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  // Storage array. It is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.i_rx_data;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state. i_full is sampled only in IDLE, and the byte is latched on entry to SEND.
  always_comb begin
    state_d = state_q;
    go_send = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !bus.i_full) begin
          go_send = 1'b1;
          state_d = SEND;
          data_d  = mem_q[rptr_q];
        end
      end
      SEND:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The strobe is high exactly in SEND, and the data register holds otherwise.
  always_comb begin
    bus.o_wr   = (state_q == SEND);
    bus.o_data = data_q;
    o_count    = count_q;
    o_overflow = ovf_q;
    o_state    = state_q;
  end

endmodule

// File: tb/tb_rx_inbox_bridge.sv
// Directed bench for rx_inbox_bridge (DEPTH=16).
module tb_rx_inbox_bridge;

  logic       clk;
  logic       rst_n;
  logic       clr_ovf;
  logic [4:0] count;
  logic       overflow;
  logic [1:0] state;

  rx_inbox_bridge_if bus();

  rx_inbox_bridge #(.DEPTH(16)) dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .i_clr_ovf  (clr_ovf),
    .o_count    (count),
    .o_overflow (overflow),
    .o_state    (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         wr_cyc_q[$];
  int         cyc = 0;
  int         b2b_viol = 0;
  int         full_viol = 0;
  logic       prev_wr = 1'b0;
  logic       prev_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture strobes at the falling edge. Record strobes in consecutive cycles and strobes that follow a full cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr   = 1'b0;
      prev_full = 1'b0;
    end else begin
      if (bus.o_wr) begin
        if (prev_wr)   b2b_viol++;
        if (prev_full) full_viol++;
        got_q.push_back(bus.o_data);
        wr_cyc_q.push_back(cyc);
      end
      prev_wr   = bus.o_wr;
      prev_full = bus.i_full;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_rx_wr   = 1'b1;
    bus.i_rx_data = b;
    step();
    bus.i_rx_wr   = 1'b0;
  endtask

  task automatic wait_empty(output bit timed_out);
    int n;
    n = 0;
    while ((count != 0 || state != 2'd0) && n < 400) begin
      step();
      n++;
    end
    timed_out = (n >= 400);
    step();
  endtask

  task automatic clear_sb;
    exp_q.delete();
    got_q.delete();
    wr_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bit to;
    int n;
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (bus.o_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0h exp=0", bus.o_wr); end
    checks++; if (bus.o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", bus.o_data); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0h exp=0", overflow); end
    rst_n = 1'b1;
    step();
    // Start a transfer, then reset in the middle of its SEND cycle.
    push(8'h55);
    n = 0;
    while (bus.o_wr !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (bus.o_wr !== 1'b1) begin failures++; $display("FAIL reset_send_reached got=%0h exp=1", bus.o_wr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_wr !== 1'b0) begin failures++; $display("FAIL async_reset_wr got=%0h exp=0", bus.o_wr); end
    checks++; if (bus.o_data !== 8'h00) begin failures++; $display("FAIL async_reset_data got=%0h exp=00", bus.o_data); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", count); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL async_reset_state got=%0d exp=0", state); end
    step();
    rst_n = 1'b1;
    step();
    clear_sb();
    exp_q.push_back(8'h66);
    push(8'h66);
    wait_empty(to);
    checks++; if (to) begin failures++; $display("FAIL reset_drain_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL reset_first_size got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL reset_first_byte got=%0h exp=%0h", got_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_single;
    clear_sb();
    push(8'h41);                     // now in cycle N+1
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL single_count_n1 got=%0d exp=1", count); end
    checks++; if (bus.o_wr !== 1'b0) begin failures++; $display("FAIL single_wr_n1 got=%0h exp=0", bus.o_wr); end
    step();                          // cycle N+2
    checks++; if (bus.o_wr !== 1'b1) begin failures++; $display("FAIL single_wr_n2 got=%0h exp=1", bus.o_wr); end
    checks++; if (bus.o_data !== 8'h41) begin failures++; $display("FAIL single_data_n2 got=%0h exp=41", bus.o_data); end
    step();                          // cycle N+3
    checks++; if (bus.o_wr !== 1'b0) begin failures++; $display("FAIL single_wr_n3 got=%0h exp=0", bus.o_wr); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL single_count_n3 got=%0d exp=0", count); end
    repeat (3) step();
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL single_strobes got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_back_pressure;
    bit to;
    clear_sb();
    bus.i_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    repeat (4) step();
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL bp_count got=%0d exp=5", count); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL bp_no_wr got=%0d exp=0", got_q.size()); end
    bus.i_full = 1'b0;
    wait_empty(to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== 5) begin failures++; $display("FAIL bp_size got=%0d exp=5", got_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 3) begin failures++; $display("FAIL bp_spacing%0d got=%0d exp=3", i, wr_cyc_q[i] - wr_cyc_q[i-1]); end
      end
    end
  endtask

  task automatic test_overflow;
    bit to;
    clear_sb();
    bus.i_full = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back(8'(i));
      push(8'(i));
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
    bus.i_full = 1'b0;
    wait_empty(to);
    checks++; if (to) begin failures++; $display("FAIL ovf_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== 16) begin failures++; $display("FAIL ovf_size got=%0d exp=16", got_q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0h exp=0", overflow); end
  endtask

  task automatic test_full_pop;
    bit to;
    clear_sb();
    bus.i_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      push(8'h20 + 8'(i));
    end
    exp_q.push_back(8'hAA);
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fp_count_pre got=%0d exp=16", count); end
    bus.i_full = 1'b0;
    step();
    checks++; if (bus.o_wr !== 1'b1) begin failures++; $display("FAIL fp_send got=%0h exp=1", bus.o_wr); end
    push(8'hAA);
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fp_count_post got=%0d exp=16", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fp_ovf got=%0h exp=0", overflow); end
    wait_empty(to);
    checks++; if (to) begin failures++; $display("FAIL fp_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== 17) begin failures++; $display("FAIL fp_size got=%0d exp=17", got_q.size()); end
    else begin
      for (int i = 0; i < 17; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fp_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    bit any_to;
    clear_sb();
    any_to = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        bus.i_full = 1'($urandom_range(0, 1));
        exp_q.push_back(8'h80 + 8'(b * 10 + i));
        push(8'h80 + 8'(b * 10 + i));
      end
      for (int i = 0; i < 8; i++) begin
        bus.i_full = 1'($urandom_range(0, 1));
        step();
      end
      bus.i_full = 1'b0;
      wait_empty(to);
      if (to) any_to = 1'b1;
    end
    checks++; if (any_to) begin failures++; $display("FAIL wrap_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== 40) begin failures++; $display("FAIL wrap_size got=%0d exp=40", got_q.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_byte%0d got=%0h exp=%0h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_ovf got=%0h exp=0", overflow); end
    checks++; if (b2b_viol !== 0) begin failures++; $display("FAIL consecutive_wr got=%0d exp=0", b2b_viol); end
    checks++; if (full_viol !== 0) begin failures++; $display("FAIL wr_after_full got=%0d exp=0", full_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n         = 1'b0;
    clr_ovf       = 1'b0;
    bus.i_rx_wr   = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_full    = 1'b0;
    test_reset();
    test_single();
    test_back_pressure();
    test_overflow();
    test_full_pop();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
